// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Rounded clk_hz / (baud * os), evaluated at elaboration time.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        longint den;
        den = longint'(baud) * longint'(os);
        return int'((longint'(clk_hz) + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output handshake of the UART receiver: data plus valid/ready.
interface uart_rx_if;

    logic [uart_pkg::DATA_BITS-1:0] data_o;
    logic                           m_valid_o;
    logic                           m_ready_i;

    modport master (
        output data_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport slave (
        input  data_o,
        input  m_valid_o,
        output m_ready_i
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: tick_o pulses once every DIV clocks, held at phase zero while clr_i=1.
module uart_baud_tick #(
    parameter int DIV = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_i,
    uart_rx_if.master m_if,
    output logic      frame_err_o,
    output logic      overrun_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic      parity_err_o
`endif
);

    localparam int DIV    = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 byte_done;
    logic                 tick;
    logic                 tick_clr;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_err_q, par_err_d;
`endif

    assign tick_clr = (state_q == IDLE);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif

        if (valid_q && m_if.m_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_bad_d  = (^shift_q) ^ rx_s_q;
                        par_err_d  = (^shift_q) ^ rx_s_q;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            // Leave at mid-stop so the next start edge is not missed.
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            byte_done = !par_bad_q;
`else
                            byte_done = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A held byte is only replaced when it is being accepted this same cycle.
        if (byte_done) begin
            if (!valid_q || m_if.m_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_i;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign m_if.data_o    = data_q;
    assign m_if.m_valid_o = valid_q;
    assign frame_err_o    = frame_err_q;
    assign overrun_o      = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, results checked with immediate assertions.
// Define UART_RX_PARITY_EN to also exercise the parity frame format.
module tb_uart_rx;
    import uart_pkg::*;

    // 25 MHz / (115200 * 16) = 13.56 -> DIV 14; one bit = 16 ticks * 14 clocks
    localparam int DIV_CLKS = 14;
    localparam int BIT_CLKS = 16 * DIV_CLKS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic frame_err;
    logic overrun;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    logic bad_parity = 1'b0;
    int   parity_cnt = 0;
    int   p0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int accept_cnt   = 0;
    int frame_cnt    = 0;
    int overrun_cnt  = 0;
    logic [7:0] last_data = 8'h00;
    int a0, f0, o0;

    uart_rx_if rx_if();

    uart_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .m_if        (rx_if),
        .frame_err_o (frame_err),
        .overrun_o   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Observe handshakes and error pulses between active edges.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_if.m_valid_o && rx_if.m_ready_i) begin
                accept_cnt = accept_cnt + 1;
                last_data  = rx_if.data_o;
            end
            if (frame_err) frame_cnt = frame_cnt + 1;
            if (overrun) overrun_cnt = overrun_cnt + 1;
`ifdef UART_RX_PARITY_EN
            if (parity_err) parity_cnt = parity_cnt + 1;
`endif
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run = tests_run + 1;
        assert (observed === expected)
        else begin
            tests_failed = tests_failed + 1;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic holdBits(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        holdBits(n * BIT_CLKS);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop_bit (left driven).
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        holdBits(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            holdBits(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_parity;
        holdBits(BIT_CLKS);
`endif
        rx = stop_bit;
        holdBits(BIT_CLKS);
    endtask

    task automatic setReady(input logic r);
        @(posedge clk);
        #1 rx_if.m_ready_i = r;
    endtask

    task automatic snapshot();
        a0 = accept_cnt;
        f0 = frame_cnt;
        o0 = overrun_cnt;
    endtask

    initial begin
        rx_if.m_ready_i = 1'b1;
        #2 rst = 1'b0;
        holdBits(5);
        checkOutput("reset_valid", 32'(rx_if.m_valid_o), 32'd0);
        checkOutput("reset_data", 32'(rx_if.data_o), 32'h00);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        idleBits(1);

        // Plain byte with consumer always ready
        snapshot();
        applyStimulus(8'hA5, 1'b1);
        idleBits(1);
        checkOutput("a5_accepts", 32'(accept_cnt - a0), 32'd1);
        checkOutput("a5_data", 32'(last_data), 32'hA5);
        checkOutput("a5_frame_err", 32'(frame_cnt - f0), 32'd0);
        checkOutput("a5_overrun", 32'(overrun_cnt - o0), 32'd0);

        // Start-bit glitch of 3 ticks is rejected
        snapshot();
        rx = 1'b0;
        holdBits(3 * DIV_CLKS);
        rx = 1'b1;
        holdBits(BIT_CLKS);
        checkOutput("glitch_accepts", 32'(accept_cnt - a0), 32'd0);
        checkOutput("glitch_state", 32'(dut.state_q), 32'(IDLE));
        applyStimulus(8'h3C, 1'b1);
        idleBits(1);
        checkOutput("3c_accepts", 32'(accept_cnt - a0), 32'd1);
        checkOutput("3c_data", 32'(last_data), 32'h3C);

        // Missing stop bit, line held in break, then recovery
        snapshot();
        applyStimulus(8'h55, 1'b0);
        rx = 1'b0;
        holdBits(2 * BIT_CLKS);
        checkOutput("break_frame_err", 32'(frame_cnt - f0), 32'd1);
        checkOutput("break_accepts", 32'(accept_cnt - a0), 32'd0);
        idleBits(1);
        applyStimulus(8'h12, 1'b1);
        idleBits(1);
        checkOutput("12_accepts", 32'(accept_cnt - a0), 32'd1);
        checkOutput("12_data", 32'(last_data), 32'h12);
        checkOutput("12_frame_err", 32'(frame_cnt - f0), 32'd1);

        // Back-to-back bytes with consumer stalled
        setReady(1'b0);
        snapshot();
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        idleBits(1);
        checkOutput("stall_valid", 32'(rx_if.m_valid_o), 32'd1);
        checkOutput("stall_data", 32'(rx_if.data_o), 32'h01);
        checkOutput("stall_overrun", 32'(overrun_cnt - o0), 32'd1);
        checkOutput("stall_accepts", 32'(accept_cnt - a0), 32'd0);
        setReady(1'b1);
        holdBits(4);
        checkOutput("drain_accepts", 32'(accept_cnt - a0), 32'd1);
        checkOutput("drain_data", 32'(last_data), 32'h01);
        checkOutput("drain_valid", 32'(rx_if.m_valid_o), 32'd0);

        // Reset in the middle of a frame while a byte is held
        setReady(1'b0);
        applyStimulus(8'h3C, 1'b1);
        idleBits(1);
        checkOutput("held_valid", 32'(rx_if.m_valid_o), 32'd1);
        rx = 1'b0;
        holdBits(BIT_CLKS);
        rx = 1'b1;
        holdBits(3 * BIT_CLKS + BIT_CLKS / 2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(rx_if.m_valid_o), 32'd0);
        checkOutput("rst_data", 32'(rx_if.data_o), 32'h00);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
        holdBits(3);
        rst = 1'b1;
        setReady(1'b1);
        idleBits(1);
        snapshot();
        applyStimulus(8'h81, 1'b1);
        idleBits(1);
        checkOutput("81_accepts", 32'(accept_cnt - a0), 32'd1);
        checkOutput("81_data", 32'(last_data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 carries parity bit 1
        snapshot();
        p0 = parity_cnt;
        bad_parity = 1'b0;
        applyStimulus(8'h07, 1'b1);
        idleBits(1);
        checkOutput("par_ok_accepts", 32'(accept_cnt - a0), 32'd1);
        checkOutput("par_ok_data", 32'(last_data), 32'h07);
        checkOutput("par_ok_err", 32'(parity_cnt - p0), 32'd0);
        snapshot();
        bad_parity = 1'b1;
        applyStimulus(8'h07, 1'b1);
        idleBits(1);
        bad_parity = 1'b0;
        checkOutput("par_bad_err", 32'(parity_cnt - p0), 32'd1);
        checkOutput("par_bad_accepts", 32'(accept_cnt - a0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
